// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters; grant 1 cycle after req, response 1 cycle after mul_done.
// Response holds under rsp_ready low and no new request is sampled until it is accepted; a missing mul_done becomes an error response.
module mult_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic [WIDTH-1:0]     a0_i,
  input  logic [WIDTH-1:0]     b0_i,
  input  logic [WIDTH-1:0]     a1_i,
  input  logic [WIDTH-1:0]     b1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 mul_start_o,
  output logic [WIDTH-1:0]     mul_a_o,
  output logic [WIDTH-1:0]     mul_b_o,
  input  logic                 mul_done_i,
  input  logic [2*WIDTH-1:0]   mul_prod_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_id_o,
  output logic [2*WIDTH-1:0]   rsp_data_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state_q;
  logic                 id_q;
  logic                 last_id_q;
  logic [TW-1:0]        timer_q;
  logic                 gnt0_q;
  logic                 gnt1_q;
  logic                 start_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 rsp_valid_q;
  logic [2*WIDTH-1:0]   data_q;
  logic                 err_q;
  logic                 busy_q;

  logic                 win_id_d;
  logic [WIDTH-1:0]     win_a_d;
  logic [WIDTH-1:0]     win_b_d;

  // On a tie the requester not served last wins.
  always_comb begin
    win_id_d = 1'b0;
    if (req0_i && req1_i) begin
      win_id_d = ~last_id_q;
    end else if (req1_i) begin
      win_id_d = 1'b1;
    end
    win_a_d = win_id_d ? a1_i : a0_i;
    win_b_d = win_id_d ? b1_i : b0_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      id_q        <= 1'b0;
      last_id_q   <= 1'b1;
      timer_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_i || req1_i) begin
            id_q    <= win_id_d;
            a_q     <= win_a_d;
            b_q     <= win_b_d;
            gnt0_q  <= ~win_id_d;
            gnt1_q  <= win_id_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last allowed cycle still wins over the timeout.
          if (mul_done_i) begin
            data_q      <= mul_prod_i;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (timer_q == TIMER_LAST) begin
            data_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            last_id_q   <= id_q;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0_o      = gnt0_q;
  assign gnt1_o      = gnt1_q;
  assign mul_start_o = start_q;
  assign mul_a_o     = a_q;
  assign mul_b_o     = b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier, response scoreboard and per-scenario tasks.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done;
  logic [15:0] mul_prod;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          model_delay = 0;
  logic        model_ovr = 1'b0;
  logic [15:0] model_val = '0;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req0_i      (req0),
    .req1_i      (req1),
    .a0_i        (a0),
    .b0_i        (b0),
    .a1_i        (a1),
    .b1_i        (b1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .mul_start_o (mul_start),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_done_i  (mul_done),
    .mul_prod_i  (mul_prod),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy)
  );

  function automatic logic [15:0] smul(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] xs;
    logic signed [15:0] ys;
    xs = 16'($signed(x));
    ys = 16'($signed(y));
    return 16'(xs * ys);
  endfunction

  // Multiplier model: done pulse model_delay cycles after the start cycle.
  initial begin
    logic [15:0] p;
    mul_done = 1'b0;
    mul_prod = 16'hDEAD;
    forever begin
      @(posedge clk);
      #2;
      if (mul_start === 1'b1 && model_delay > 0) begin
        if (model_ovr) p = model_val;
        else           p = smul(mul_a, mul_b);
        repeat (model_delay) @(posedge clk);
        #1;
        mul_done = 1'b1;
        mul_prod = p;
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        mul_prod = 16'hDEAD;
      end
    end
  end

  // Response scoreboard and grant exclusivity, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (gnt0 || gnt1) begin
        total++;
        if (gnt0 && gnt1) begin
          bad++;
          $display("FAIL gnt_exclusive got gnt0=%0b gnt1=%0b expected one-hot", gnt0, gnt1);
        end
      end
      if (rsp_valid && rsp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected got id=%0b data=%h err=%0b expected no response", rsp_id, rsp_data, rsp_err);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data, rsp_err} !== e) begin
            bad++;
            $display("FAIL rsp_compare got id=%0b data=%h err=%0b expected id=%0b data=%h err=%0b",
                     rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    tick();
    while (!(gnt0 || gnt1) && n < 80) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_wait got busy=%b expected 0", busy);
    end
  endtask

  // Cycles from the grant cycle to the first rsp_valid cycle.
  task automatic rsp_latency(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({gnt0, gnt1, mul_start, rsp_valid, rsp_err, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got %b expected 000000", {gnt0, gnt1, mul_start, rsp_valid, rsp_err, busy});
    end
    total++;
    if ({mul_a, mul_b} !== 16'h0) begin
      bad++;
      $display("FAIL reset_operands got %h expected 0000", {mul_a, mul_b});
    end
    total++;
    if (rsp_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_data got %h expected 0000", rsp_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    model_delay = 5;
    model_ovr   = 1'b0;
    rsp_ready   = 1'b1;
    a0 = 8'h01;
    b0 = 8'h33;
    req0 = 1'b1;
    sb.push_back('{1'b0, 16'h0033, 1'b0});
    tick();
    total++;
    if ({gnt0, gnt1, mul_start} !== 3'b101) begin
      bad++;
      $display("FAIL single_grant got gnt0/gnt1/start=%b expected 101", {gnt0, gnt1, mul_start});
    end
    total++;
    if ({mul_a, mul_b} !== 16'h0133) begin
      bad++;
      $display("FAIL single_operands got %h expected 0133", {mul_a, mul_b});
    end
    req0 = 1'b0;
    a0 = 8'h55;
    tick();
    total++;
    if ({gnt0, mul_start, busy, mul_a} !== {3'b001, 8'h01}) begin
      bad++;
      $display("FAIL single_pulse got gnt0/start/busy=%b mul_a=%h expected 001 and 01",
               {gnt0, mul_start, busy}, mul_a);
    end
    rsp_latency(n);
    total++;
    if (n + 1 !== 6) begin
      bad++;
      $display("FAIL single_latency got %0d expected 6", n + 1);
    end
    wait_idle();
  endtask

  task automatic test_tie();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_delay = 2;
    model_ovr   = 1'b0;
    for (int round = 0; round < 2; round++) begin
      a0 = 8'h02; b0 = 8'h03;
      a1 = 8'hFD; b1 = 8'h05;
      sb.push_back('{1'b0, 16'h0006, 1'b0});
      sb.push_back('{1'b1, 16'hFFF1, 1'b0});
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
        bad++;
        $display("FAIL tie_first round=%0d got gnt0/gnt1=%b expected 10", round, {gnt0, gnt1});
      end
      req0 = 1'b0;
      wait_gnt();
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
        bad++;
        $display("FAIL tie_second round=%0d got gnt0/gnt1=%b expected 01", round, {gnt0, gnt1});
      end
      req1 = 1'b0;
      wait_idle();
    end
  endtask

  task automatic test_timeout();
    int n;
    model_delay = 0;
    a0 = 8'h07; b0 = 8'h09;
    req0 = 1'b1;
    sb.push_back('{1'b0, 16'h0000, 1'b1});
    tick();
    req0 = 1'b0;
    rsp_latency(n);
    total++;
    if (n !== 17) begin
      bad++;
      $display("FAIL timeout_latency got %0d expected 17", n);
    end
    total++;
    if ({rsp_err, rsp_data} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL timeout_rsp got err=%b data=%h expected err=1 data=0000", rsp_err, rsp_data);
    end
    wait_idle();
  endtask

  task automatic test_done_last();
    int n;
    model_delay = 16;
    model_ovr   = 1'b1;
    model_val   = 16'h1234;
    a1 = 8'h11; b1 = 8'h22;
    req1 = 1'b1;
    sb.push_back('{1'b1, 16'h1234, 1'b0});
    tick();
    req1 = 1'b0;
    rsp_latency(n);
    total++;
    if (n !== 17) begin
      bad++;
      $display("FAIL done_last_latency got %0d expected 17", n);
    end
    total++;
    if ({rsp_err, rsp_data} !== {1'b0, 16'h1234}) begin
      bad++;
      $display("FAIL done_last_rsp got err=%b data=%h expected err=0 data=1234", rsp_err, rsp_data);
    end
    model_ovr = 1'b0;
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n;
    logic stable;
    model_delay = 2;
    model_ovr   = 1'b0;
    rsp_ready   = 1'b0;
    a0 = 8'h81; b0 = 8'h02;
    req0 = 1'b1;
    sb.push_back('{1'b0, 16'hFF02, 1'b0});
    tick();
    req0 = 1'b0;
    rsp_latency(n);
    a1 = 8'h03; b1 = 8'h04;
    req1 = 1'b1;
    sb.push_back('{1'b1, smul(8'h03, 8'h04), 1'b0});
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hFF02 || gnt0 !== 1'b0 || gnt1 !== 1'b0) stable = 1'b0;
      tick();
    end
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got stable=%b (valid=%b data=%h) expected 1 valid=1 data=ff02",
               stable, rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if ({gnt1, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL bp_after_hs got gnt1/valid=%b expected 00", {gnt1, rsp_valid});
    end
    tick();
    total++;
    if ({gnt0, gnt1} !== 2'b01) begin
      bad++;
      $display("FAIL bp_next_grant got gnt0/gnt1=%b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_wait();
    logic quiet;
    model_delay = 4;
    model_ovr   = 1'b0;
    a0 = 8'h05; b0 = 8'h05;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || busy || gnt0 || gnt1 || mul_start) quiet = 1'b0;
      tick();
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_quiet got activity after reset expected none");
    end
    total++;
    if ({mul_a, mul_b, rsp_data, rsp_err} !== 33'h0) begin
      bad++;
      $display("FAIL rst_wait_values got a/b=%h data=%h err=%b expected all zero", {mul_a, mul_b}, rsp_data, rsp_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_done_last();
    test_backpressure();
    test_reset_wait();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_drained got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, 8, operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, 16, maximum WAIT cycles allowed before mul_done must arrive.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  operation requests from requesters 0 and 1.
REQ-006 a0, b0, a1, b1  input  WIDTH each  signed operands for each requester.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulses.
REQ-008 mul_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-009 mul_a, mul_b  output  WIDTH each  operands to the multiplier.
REQ-010 mul_done  input  1  multiplier completion pulse.
REQ-011 mul_prod  input  2*WIDTH  multiplier product, valid only while mul_done=1.
REQ-012 rsp_valid  output  1  a response is pending.
REQ-013 rsp_ready  input  1  response consumer accepts the response.
REQ-014 rsp_id  output  1  requester that owns the response.
REQ-015 rsp_data  output  2*WIDTH  product.
REQ-016 rsp_err  output  1  set when the response is a timeout response.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT and RESP, and only the transitions in REQ-019 to REQ-023.
REQ-019 IDLE: if any req is sampled high, the FSM SHALL latch the winner's id and operands and move to START; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration: a single request SHALL win; if both are high, the requester other than last_id SHALL win (round robin).
REQ-021 START lasts exactly 1 cycle. It SHALL drive gnt[id]=1, mul_start=1 and mul_a/mul_b = the latched operands, then go to WAIT.
REQ-022 WAIT:
- mul_done=1 SHALL capture mul_prod into rsp_data, clear rsp_err and go to RESP.
- Otherwise the timer SHALL increment.
- After TIMEOUT consecutive WAIT cycles without mul_done, the FSM SHALL go to RESP with rsp_data=0 and rsp_err=1.
REQ-023 RESP: rsp_valid=1, with rsp_id/rsp_data/rsp_err held stable until rsp_ready=1. On that cycle the FSM SHALL update last_id=rsp_id and go to IDLE.
REQ-024 mul_a and mul_b SHALL stay stable from START until leaving WAIT.
REQ-025 mul_done SHALL be ignored outside WAIT.
REQ-026 If mul_done=1 on the TIMEOUT-th WAIT cycle, done SHALL take priority over timeout.
REQ-027 req inputs SHALL be sampled only in IDLE. Requesters SHALL hold req until they see gnt and drop it the cycle after. A req still high on return to IDLE SHALL count as a new request.
REQ-028 gnt0 and gnt1 SHALL never be high together; at most one mul_start SHALL occur per grant.
REQ-029 Minimum latency:
- req sampled at cycle t: gnt/mul_start at t+1.
- mul_done at t+1+k (k>=1): rsp_valid at t+2+k.
REQ-030 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-031 The timer SHALL be wide enough to count to TIMEOUT and SHALL clear on entry to WAIT.

Reset
REQ-032 On reset=1 at a clock edge:
- state SHALL be IDLE and last_id=1, so requester 0 wins the first tie.
- gnt0/gnt1, mul_start, rsp_valid, rsp_err and busy SHALL be 0.
- mul_a/mul_b and rsp_data SHALL be 0; the timer SHALL be 0.
REQ-033 Reset during any state SHALL abandon the operation without a response; a later mul_done SHALL be ignored.

Verification
REQ-034 Single request: req0=1 with a0=0x01, b0=0x33; model returns 0x0033 after 5 cycles -> gnt0 pulse, mul_start 1 cycle, rsp_valid with rsp_id=0, rsp_data=0x0033, rsp_err=0.
REQ-035 Tie after reset: req0=req1=1 with a1=0xFD, b1=0x05 -> requester 0 is served first. Requester 1 is then granted with no other requests, giving rsp_data=0xFFF1 and rsp_id=1. A further tie is then granted to 0.
REQ-036 Timeout: mul_done never asserted -> after 16 WAIT cycles rsp_valid=1, rsp_err=1, rsp_data=0x0000.
REQ-037 Done on the 16th WAIT cycle with mul_prod=0x1234 -> rsp_err=0, rsp_data=0x1234.
REQ-038 Backpressure: rsp_ready low for 10 cycles -> rsp_valid and rsp_data stable throughout, no new grant, and req1 is not granted until the cycle after handshake plus 1.
REQ-039 Reset asserted in WAIT, then mul_done pulses -> outputs at reset values, no rsp_valid, busy=0.
